// File: rtl/trv32i_sim_monitor.sv
// Run-control monitor for TRV32I simulation/bring-up: halt/error/timeout detection, drain, sticky verdict, counters.
// Optional stuck-PC detector is built only when TRV_MON_LOOPDET_EN is defined.
module trv32i_sim_monitor #(
  parameter int          XLEN           = 32,
  parameter int          CNT_WIDTH      = 32,
  parameter logic [31:0] HALT_INST      = 32'h00000073,
  parameter logic [31:0] ALT_HALT_INST  = 32'h00100073,
  parameter int          DRAIN_CYCLES   = 3,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter int          LOOP_LIMIT     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [XLEN-1:0]      pc,
  input  logic [XLEN-1:0]      inst,
  input  logic                 inst_valid,
  input  logic                 bus_read_en,
  input  logic                 bus_write_en,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic [2:0]           fail_code,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] inst_cnt,
  output logic [CNT_WIDTH-1:0] rd_cnt,
  output logic [CNT_WIDTH-1:0] wr_cnt
);

  localparam int DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_PASS,
    ST_FAIL
  } state_t;

  state_t          state;
  logic [DW-1:0]   drain_cnt;
  logic            drain_pass;

  logic            inst_unknown;
  logic            bad_op;
  logic            is_halt;
  logic            timeout_hit;
  logic            loop_hit;
  logic            go_drain;
  logic            go_pass;
  logic [2:0]      go_code;

`ifndef SYNTHESIS
  assign inst_unknown = inst_valid && $isunknown(inst);
`else
  assign inst_unknown = 1'b0;
`endif

  assign bad_op      = inst_valid && (inst[1:0] != 2'b11);
  assign is_halt     = inst_valid && ((inst == XLEN'(HALT_INST)) || (inst == XLEN'(ALT_HALT_INST)));
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

`ifdef TRV_MON_LOOPDET_EN
  localparam int LW = $clog2(LOOP_LIMIT + 1);

  logic [XLEN-1:0] last_pc;
  logic [LW-1:0]   loop_cnt;
  logic            same_pc;

  assign same_pc  = inst_valid && (pc == last_pc);
  // Fires on the retirement that would bring the same-pc run to LOOP_LIMIT.
  assign loop_hit = same_pc && ((32'(loop_cnt) + 32'd1) >= 32'(LOOP_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      last_pc  <= '0;
      loop_cnt <= '0;
    end else if (state == ST_RUN && inst_valid) begin
      last_pc  <= pc;
      loop_cnt <= same_pc ? loop_cnt + LW'(1) : '0;
    end
  end
`else
  logic unused_loop;
  assign unused_loop = ^{pc, 1'(LOOP_LIMIT)};
  assign loop_hit    = 1'b0;
`endif

  always_comb begin
    go_drain = 1'b1;
    go_pass  = 1'b0;
    go_code  = 3'd0;
    if (inst_unknown) begin
      go_code = 3'd2;
    end else if (bad_op) begin
      go_code = 3'd1;
    end else if (is_halt) begin
      go_pass = 1'b1;
    end else if (timeout_hit) begin
      go_code = 3'd3;
    end else if (loop_hit) begin
      go_code = 3'd4;
    end else begin
      go_drain = 1'b0;
    end
  end

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_WIDTH'(1) : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      drain_cnt  <= '0;
      drain_pass <= 1'b0;
      fail_code  <= 3'd0;
      cycle_cnt  <= '0;
      inst_cnt   <= '0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          // The cycle that leaves RUN is still counted.
          cycle_cnt <= sat_inc(cycle_cnt, 1'b1);
          inst_cnt  <= sat_inc(inst_cnt, inst_valid);
          rd_cnt    <= sat_inc(rd_cnt, bus_read_en);
          wr_cnt    <= sat_inc(wr_cnt, bus_write_en);
          if (go_drain) begin
            state      <= ST_DRAIN;
            drain_cnt  <= DW'(DRAIN_CYCLES);
            drain_pass <= go_pass;
            fail_code  <= go_code;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) begin
            state <= drain_pass ? ST_PASS : ST_FAIL;
            done  <= 1'b1;
            pass  <= drain_pass;
            fail  <= !drain_pass;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule
